// File: rtl/mp3_frame_sync.sv
// mp3_frame_sync: MPEG-1 Layer III sync hunt, header parse, CRC strip and payload forwarding with frame lock tracking.
module mp3_frame_sync #(
  parameter int DWIDTH = 8,
  parameter int LENW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [DWIDTH-1:0] payload_data,
  output logic              payload_valid,
  input  logic              payload_ready,
  output logic              payload_first,
  output logic              payload_last,
  output logic              hdr_valid,
  output logic [3:0]        bitrate_idx,
  output logic [1:0]        fs_idx,
  output logic              padding,
  output logic [1:0]        chan_mode,
  output logic              crc_present,
  output logic [LENW-1:0]   frame_len,
  output logic              locked,
  output logic              sync_err
);
  typedef enum logic [2:0] {HUNT, H1, H2, H3, CRC0, CRC1, PAY} state_t;
  state_t state_q;
  logic prot_q, pad_q, cont_q, first_q;
  logic [3:0] br_q;
  logic [1:0] fs_q;
  logic [LENW-1:0] rem_q, base_d, flen_d;
  logic [3*LENW-1:0] row_d;
  logic acc, is_ff, h2_bad;
  assign byte_ready = (state_q != PAY) || !payload_valid || payload_ready;
  assign acc = byte_valid && byte_ready;
  assign is_ff = byte_in == {DWIDTH{1'b1}};
  assign h2_bad = byte_in[7:4] == 4'h0 || byte_in[7:4] == 4'hF || byte_in[3:2] == 2'b11;
  // Frame bytes without padding, columns ordered 44.1 / 48 / 32 kHz
  always_comb begin
    case (br_q)
      4'd1:    row_d = {11'd104,  11'd96,  11'd144};
      4'd2:    row_d = {11'd130,  11'd120, 11'd180};
      4'd3:    row_d = {11'd156,  11'd144, 11'd216};
      4'd4:    row_d = {11'd182,  11'd168, 11'd252};
      4'd5:    row_d = {11'd208,  11'd192, 11'd288};
      4'd6:    row_d = {11'd261,  11'd240, 11'd360};
      4'd7:    row_d = {11'd313,  11'd288, 11'd432};
      4'd8:    row_d = {11'd365,  11'd336, 11'd504};
      4'd9:    row_d = {11'd417,  11'd384, 11'd576};
      4'd10:   row_d = {11'd522,  11'd480, 11'd720};
      4'd11:   row_d = {11'd626,  11'd576, 11'd864};
      4'd12:   row_d = {11'd731,  11'd672, 11'd1008};
      4'd13:   row_d = {11'd835,  11'd768, 11'd1152};
      4'd14:   row_d = {11'd1044, 11'd960, 11'd1440};
      default: row_d = '0;
    endcase
    base_d = fs_q == 2'd0 ? row_d[3*LENW-1:2*LENW] : fs_q == 2'd1 ? row_d[2*LENW-1:LENW] : row_d[LENW-1:0];
    flen_d = base_d + LENW'(pad_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      prot_q <= 1'b0;
      pad_q <= 1'b0;
      cont_q <= 1'b0;
      first_q <= 1'b0;
      br_q <= '0;
      fs_q <= '0;
      rem_q <= '0;
      payload_data <= '0;
      payload_valid <= 1'b0;
      payload_first <= 1'b0;
      payload_last <= 1'b0;
      hdr_valid <= 1'b0;
      bitrate_idx <= '0;
      fs_idx <= '0;
      padding <= 1'b0;
      chan_mode <= '0;
      crc_present <= 1'b0;
      frame_len <= '0;
      locked <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      sync_err <= 1'b0;
      if (payload_ready) payload_valid <= 1'b0;
      if (acc) begin
        case (state_q)
          HUNT: begin
            if (is_ff) state_q <= H1;
            else if (cont_q) begin
              sync_err <= 1'b1;
              locked <= 1'b0;
              cont_q <= 1'b0;
            end
          end
          H1: begin
            if (byte_in[7:1] == 7'b1111101) begin
              state_q <= H2;
              prot_q <= byte_in[0];
            end else begin
              sync_err <= 1'b1;
              locked <= 1'b0;
              cont_q <= 1'b0;
              state_q <= is_ff ? H1 : HUNT;
            end
          end
          H2: begin
            br_q <= byte_in[7:4];
            fs_q <= byte_in[3:2];
            pad_q <= byte_in[1];
            state_q <= h2_bad ? HUNT : H3;
            if (h2_bad) begin
              sync_err <= 1'b1;
              locked <= 1'b0;
              cont_q <= 1'b0;
            end
          end
          H3: begin
            hdr_valid <= 1'b1;
            bitrate_idx <= br_q;
            fs_idx <= fs_q;
            padding <= pad_q;
            chan_mode <= byte_in[7:6];
            crc_present <= !prot_q;
            frame_len <= flen_d;
            locked <= cont_q;
            cont_q <= 1'b0;
            rem_q <= flen_d - (prot_q ? LENW'(4) : LENW'(6));
            first_q <= 1'b1;
            state_q <= prot_q ? PAY : CRC0;
          end
          CRC0: state_q <= CRC1;
          CRC1: state_q <= PAY;
          PAY: begin
            payload_data <= byte_in;
            payload_valid <= 1'b1;
            payload_first <= first_q;
            payload_last <= rem_q == LENW'(1);
            first_q <= 1'b0;
            rem_q <= rem_q - LENW'(1);
            // A clean frame end arms the next header as a lock candidate
            if (rem_q == LENW'(1)) begin
              state_q <= HUNT;
              cont_q <= 1'b1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end
endmodule
